s_stream_packer: RTL
====================

Name: s_stream_packer

Overview:
- Upstream feeder for the S-sequence port of the alignment top level.
- Accepts a host byte stream of ASCII nucleotides over a valid/ready handshake and encodes each to 2 bits.
- Packs the encoded bases into PE-array-wide chunks and delivers one chunk per top-level S request, as a packed vector plus a valid-base count.
- Double-buffered (assembly register plus holding register), so the host keeps streaming while a full chunk waits for a request.

Parameters:
- PE_SIZE, default 64: bases per chunk; equals the PE array size.
- PE_SIZE_LOG, default 6: log2(PE_SIZE).

Ports:
- clk  in  1  Clock; all logic on the rising edge.
- rst  in  1  Reset, synchronous and active-high.
- i_char  in  8  ASCII character from the host.
- i_char_valid  in  1  i_char is valid.
- i_char_last  in  1  i_char is the final character of the current S sequence.
- o_char_ready  out  1  Block accepts i_char this cycle.
- i_request_s  in  1  Single-cycle pulse from the top level asking for the next chunk.
- o_s  out  2*PE_SIZE  Packed chunk; base k sits at bits [2k+1:2k]; base 0 is the first received.
- o_s_valid  out  PE_SIZE_LOG+1  Number of valid bases in o_s (1..PE_SIZE); 0 means no chunk this cycle.
- o_seq_done  out  1  Pulse coincident with delivery of a sequence's last chunk.
- o_bad_char  out  1  Sticky flag: a non-nucleotide character was dropped.
- o_busy  out  1  Assembly count nonzero, holding register full, or request pending.

Behaviour:
- Encoding: A/a=00, C/c=01, G/g=10, T/t=11. Any other character is dropped and sets o_bad_char.
  - If a dropped character carries i_char_last, it still closes the sequence.
- Handshake: a transfer occurs when i_char_valid & o_char_ready. o_char_ready = ~asm_full, where asm_full means the assembly chunk is closed and not yet moved.
- Assembly:
  - Register asm_data, counter asm_cnt (0..PE_SIZE), flag asm_last.
  - Each accepted valid base is written at index asm_cnt, then asm_cnt increments.
  - The chunk closes when asm_cnt reaches PE_SIZE, or when i_char_last is accepted.
  - Unused base slots are zero.
- A last character arriving when asm_cnt=0 and dropped produces no chunk; o_seq_done then pulses with the next delivered chunk's sequence. An empty sequence yields nothing.
- Move: a closed assembly chunk moves to the holding register (hold_data, hold_cnt, hold_last, hold_vld) in the cycle after closing, if hold_vld=0 or hold is emptied that same cycle. asm_cnt clears on move.
- Request:
  - i_request_s sets req_pend.
  - A pulse while req_pend=1 is ignored; one outstanding request maximum.
- Delivery:
  - When req_pend & hold_vld, the next cycle registers o_s=hold_data, o_s_valid=hold_cnt, o_seq_done=hold_last.
  - Same edge clears req_pend and hold_vld.
  - Outputs are valid for exactly one cycle; o_s_valid, o_seq_done and o_s return to 0 after.
- Latency:
  - Request at cycle n with hold valid -> o_s_valid nonzero at n+1.
  - Hold empty: delivery one cycle after hold fills.
  - Character closing a chunk at n, hold empty, request pending -> delivery at n+2.
- Simultaneous events:
  - Request pulse, hold delivery and asm->hold move can share one edge.
  - Char accept and move in the same cycle: impossible by design (ready low while full).
- Full: assembly closed and hold occupied -> o_char_ready=0 until a request drains hold.
- Reset (any time, including mid-chunk):
  - Registers clear: asm_cnt=0, hold_vld=0, req_pend=0.
  - Outputs: o_s=0, o_s_valid=0, o_seq_done=0, o_bad_char=0, o_busy=0.
  - o_char_ready=1 from the first cycle after reset.
  - Partial chunks are discarded.
- Width rule: o_s_valid uses PE_SIZE_LOG+1 bits so that PE_SIZE is representable.

Test Plan (PE_SIZE=4, PE_SIZE_LOG=2):
- Stream "ACGT" (last on T), then one request -> o_s=8'b11100100, o_s_valid=4, o_seq_done=1, one cycle, one cycle after the request.
- Stream "ACGTGA" (last on A), two requests spaced 5 cycles apart -> first o_s=8'hE4/valid 4/done 0; second o_s=8'h02/valid 2/done 1.
- Stream "acNgt" (last on t) -> N dropped, o_bad_char=1, chunk 8'hE4 valid 4 done 1; lowercase accepted.
- Stream 12 bases with no request -> o_char_ready falls after the 8th base (asm+hold full). Request -> first chunk delivered, ready rises, the remaining 4 bases are taken.
- Request pulse before any data, then 4 bases -> delivery exactly 2 cycles after the 4th accepted base. A second request pulse while pending is ignored (only one delivery).
- Assert rst for one cycle after 3 bases -> all outputs 0, o_char_ready=1. A following 4-base sequence + request delivers only the new bases.

Source files
------------

// File: rtl/s_stream_packer.sv
// ASCII nucleotide stream to 2-bit packed PE-array chunks, with an assembly
// register and a holding register so the host can keep streaming while a full chunk waits.
module s_stream_packer #(
  parameter int PE_SIZE     = 64,
  parameter int PE_SIZE_LOG = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_char,
  input  logic                     i_char_valid,
  input  logic                     i_char_last,
  output logic                     o_char_ready,
  input  logic                     i_request_s,
  output logic [2*PE_SIZE-1:0]     o_s,
  output logic [PE_SIZE_LOG:0]     o_s_valid,
  output logic                     o_seq_done,
  output logic                     o_bad_char,
  output logic                     o_busy
);
  localparam int CW = PE_SIZE_LOG + 1;

  logic [2*PE_SIZE-1:0] asm_data_q, asm_data_d, hold_data_q, hold_data_d, o_s_q, o_s_d;
  logic [CW-1:0]        asm_cnt_q, asm_cnt_d, hold_cnt_q, hold_cnt_d, o_s_valid_q, o_s_valid_d;
  logic                 asm_last_q, asm_last_d, hold_last_q, hold_last_d;
  logic                 hold_vld_q, hold_vld_d, req_pend_q, req_pend_d;
  logic                 o_seq_done_q, o_seq_done_d, bad_q, bad_d;

  logic       is_base;
  logic [1:0] code;
  logic       asm_full, accept, req_eff, deliver_hold, deliver_asm, move;

  always_comb begin
    is_base = 1'b1;
    code    = 2'b00;
    case (i_char)
      8'h41, 8'h61: code = 2'b00;
      8'h43, 8'h63: code = 2'b01;
      8'h47, 8'h67: code = 2'b10;
      8'h54, 8'h74: code = 2'b11;
      default:      is_base = 1'b0;
    endcase
  end

  assign asm_full     = asm_last_q | (asm_cnt_q == CW'(PE_SIZE));
  assign o_char_ready = ~asm_full;
  assign accept       = i_char_valid & ~asm_full;
  assign req_eff      = req_pend_q | i_request_s;
  assign deliver_hold = req_eff & hold_vld_q;
  // With the hold register empty, a pending request takes the closed chunk straight from assembly.
  assign deliver_asm  = req_eff & ~hold_vld_q & asm_full;
  assign move         = asm_full & (hold_vld_q ? deliver_hold : ~req_eff);

  always_comb begin
    asm_data_d   = asm_data_q;
    asm_cnt_d    = asm_cnt_q;
    asm_last_d   = asm_last_q;
    hold_data_d  = hold_data_q;
    hold_cnt_d   = hold_cnt_q;
    hold_last_d  = hold_last_q;
    hold_vld_d   = hold_vld_q;
    o_s_d        = '0;
    o_s_valid_d  = '0;
    o_seq_done_d = 1'b0;
    bad_d        = bad_q | (accept & ~is_base);
    req_pend_d   = req_eff & ~(deliver_hold | deliver_asm);

    if (deliver_hold) begin
      o_s_d        = hold_data_q;
      o_s_valid_d  = hold_cnt_q;
      o_seq_done_d = hold_last_q;
      hold_vld_d   = 1'b0;
    end else if (deliver_asm) begin
      o_s_d        = asm_data_q;
      o_s_valid_d  = asm_cnt_q;
      o_seq_done_d = asm_last_q;
    end

    if (move) begin
      hold_data_d = asm_data_q;
      hold_cnt_d  = asm_cnt_q;
      hold_last_d = asm_last_q;
      hold_vld_d  = 1'b1;
    end

    if (move || deliver_asm) begin
      asm_data_d = '0;
      asm_cnt_d  = '0;
      asm_last_d = 1'b0;
    end else if (accept) begin
      if (is_base) begin
        for (int k = 0; k < PE_SIZE; k++)
          if (asm_cnt_q == CW'(k)) asm_data_d[2*k +: 2] = code;
        asm_cnt_d = asm_cnt_q + CW'(1);
      end
      // A dropped last character on an empty assembly closes nothing.
      if (i_char_last && (is_base || asm_cnt_q != '0)) asm_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_data_q   <= '0;
      asm_cnt_q    <= '0;
      asm_last_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_cnt_q   <= '0;
      hold_last_q  <= 1'b0;
      hold_vld_q   <= 1'b0;
      req_pend_q   <= 1'b0;
      o_s_q        <= '0;
      o_s_valid_q  <= '0;
      o_seq_done_q <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      asm_data_q   <= asm_data_d;
      asm_cnt_q    <= asm_cnt_d;
      asm_last_q   <= asm_last_d;
      hold_data_q  <= hold_data_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_last_q  <= hold_last_d;
      hold_vld_q   <= hold_vld_d;
      req_pend_q   <= req_pend_d;
      o_s_q        <= o_s_d;
      o_s_valid_q  <= o_s_valid_d;
      o_seq_done_q <= o_seq_done_d;
      bad_q        <= bad_d;
    end
  end

  assign o_s        = o_s_q;
  assign o_s_valid  = o_s_valid_q;
  assign o_seq_done = o_seq_done_q;
  assign o_bad_char = bad_q;
  assign o_busy     = (asm_cnt_q != '0) | hold_vld_q | req_pend_q;

endmodule
